// File: rtl/time_register_pkg.sv
// Shared definitions for the time_register block: FSM state encodings,
// BCD counter moduli and digit limits, and a small width helper.
package time_register_pkg;

  // Legacy-compatible state encodings, wrapped by an enum for internal use.
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_SET_HRS = 2'd1;
  localparam logic [1:0] ST_SET_MIN = 2'd2;

  typedef enum logic [1:0] {
    RUN     = ST_RUN,
    SET_HRS = ST_SET_HRS,
    SET_MIN = ST_SET_MIN
  } state_t;

  // Counter moduli.
  localparam int unsigned SEC_MODULUS = 60;
  localparam int unsigned MIN_MODULUS = 60;
  localparam int unsigned HRS_MODULUS = 24;

  // Largest legal values.
  localparam int unsigned SEC_MAX      = 59;
  localparam int unsigned MIN_MAX      = 59;
  localparam int unsigned HRS_MAX      = 23;
  localparam int unsigned ONES_MAX     = 9;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned MIN_TENS_MAX = 5;
  localparam int unsigned HRS_TENS_MAX = 2;

  // Tens-digit widths of the output ports.
  localparam int unsigned SEC_TENS_W = 3;
  localparam int unsigned MIN_TENS_W = 3;
  localparam int unsigned HRS_TENS_W = 2;

  // Bits needed to hold values 0..n (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/time_register_bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping at MODULUS-1 -> 00.
// Ports:
//   i_clk    - rising-edge clock
//   i_reset  - asynchronous active-high reset, clears to 00
//   i_inc    - advance by one this cycle
//   i_clr    - clear to 00 this cycle (wins over i_inc)
//   o_tens   - tens digit (TENS_W bits)
//   o_ones   - ones digit
//   o_carry  - combinational: high when i_inc wraps the counter this cycle
module bcd_mod_counter
  import time_register_pkg::*;
#(
  parameter int unsigned MODULUS = 60,
  parameter int unsigned TENS_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [TENS_W-1:0] o_tens,
  output logic [3:0]        o_ones,
  output logic              o_carry
);

  // Last value before wrap, split into digits (e.g. 23 -> 2/3 for hours).
  localparam logic [TENS_W-1:0] TENS_LAST = TENS_W'((MODULUS - 1) / 10);
  localparam logic [3:0]        ONES_LAST = 4'((MODULUS - 1) % 10);
  localparam logic [3:0]        ONES_TOP  = 4'(ONES_MAX);

  logic at_last;

  assign at_last = (o_tens == TENS_LAST) && (o_ones == ONES_LAST);
  assign o_carry = i_inc && !i_clr && at_last;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_tens <= '0;
      o_ones <= '0;
    end else if (i_clr) begin
      o_tens <= '0;
      o_ones <= '0;
    end else if (i_inc) begin
      if (at_last) begin
        o_tens <= '0;
        o_ones <= '0;
      end else if (o_ones == ONES_TOP) begin
        o_tens <= o_tens + TENS_W'(1);
        o_ones <= '0;
      end else begin
        o_ones <= o_ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_register.sv
// time_register: 24 h BCD time-of-day register with run and set modes.
// Ports:
//   i_clk, i_reset          - clock, async active-high reset
//   i_en                    - global enable; strobes ignored when low
//   i_1hz_stb               - timekeeping strobe (counted in RUN)
//   i_timeset_stb           - adjust strobe (counted in SET_HRS / SET_MIN)
//   i_set_hours/minutes     - set buttons; hours has priority
//   o_hours_*/o_min_*/o_sec_* - registered BCD time
//   o_fast_set              - high once FAST_SET_DELAY strobes applied in the current set mode
//   o_day_stb               - one-cycle pulse on the 23:59:59 -> 00:00:00 rollover
module time_register
  import time_register_pkg::*;
#(
  parameter int unsigned FAST_SET_DELAY = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_1hz_stb,
  input  logic       i_timeset_stb,
  input  logic       i_set_hours,
  input  logic       i_set_minutes,
  output logic [1:0] o_hours_tens,
  output logic [3:0] o_hours_ones,
  output logic [2:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [2:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic       o_fast_set,
  output logic       o_day_stb
);

  localparam int unsigned       CNT_W     = cnt_width(FAST_SET_DELAY);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_SET_DELAY);

  state_t           state;
  state_t           next_state;
  logic             state_change;
  logic             run_tick;
  logic             set_tick;
  logic             sec_inc, sec_clr, sec_carry;
  logic             min_inc, min_carry;
  logic             hrs_inc, hrs_carry;
  logic [CNT_W-1:0] strobe_cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    if (i_set_hours)        next_state = SET_HRS;
    else if (i_set_minutes) next_state = SET_MIN;
    else                    next_state = RUN;
  end

  // Strobes are qualified by next_state so that the first cycle of a new
  // mode already acts according to that mode.
  assign state_change = (next_state != state);
  assign run_tick     = i_en && i_1hz_stb     && (next_state == RUN);
  assign set_tick     = i_en && i_timeset_stb && (next_state != RUN);

  assign sec_inc = run_tick;
  assign sec_clr = set_tick && (next_state == SET_MIN);
  // Minute carry feeds hours only in RUN; set-mode wraps stay local.
  assign min_inc = (run_tick && sec_carry) || (set_tick && (next_state == SET_MIN));
  assign hrs_inc = (run_tick && min_carry) || (set_tick && (next_state == SET_HRS));

  bcd_mod_counter #(
    .MODULUS(SEC_MODULUS),
    .TENS_W (SEC_TENS_W)
  ) u_sec (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_inc  (sec_inc),
    .i_clr  (sec_clr),
    .o_tens (o_sec_tens),
    .o_ones (o_sec_ones),
    .o_carry(sec_carry)
  );

  bcd_mod_counter #(
    .MODULUS(MIN_MODULUS),
    .TENS_W (MIN_TENS_W)
  ) u_min (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_inc  (min_inc),
    .i_clr  (1'b0),
    .o_tens (o_min_tens),
    .o_ones (o_min_ones),
    .o_carry(min_carry)
  );

  bcd_mod_counter #(
    .MODULUS(HRS_MODULUS),
    .TENS_W (HRS_TENS_W)
  ) u_hrs (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_inc  (hrs_inc),
    .i_clr  (1'b0),
    .o_tens (o_hours_tens),
    .o_ones (o_hours_ones),
    .o_carry(hrs_carry)
  );

  // A mode change restarts the count; a strobe landing on that same cycle
  // is the first strobe of the new mode.
  always_comb begin
    cnt_next = strobe_cnt;
    if (state_change) begin
      cnt_next = set_tick ? CNT_W'(1) : '0;
    end else if (set_tick && (strobe_cnt != FAST_LAST)) begin
      cnt_next = strobe_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= RUN;
      strobe_cnt <= '0;
      o_fast_set <= 1'b0;
      o_day_stb  <= 1'b0;
    end else begin
      state      <= next_state;
      strobe_cnt <= cnt_next;
      o_fast_set <= (cnt_next == FAST_LAST);
      o_day_stb  <= run_tick && hrs_carry;
    end
  end

endmodule

// File: tb/tb_time_register.sv
module tb_time_register;

  localparam int unsigned DELAY = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       s1  = 1'b0;
  logic       ts  = 1'b0;
  logic       sh  = 1'b0;
  logic       sm  = 1'b0;
  logic [1:0] h10;
  logic [3:0] h1;
  logic [2:0] m10;
  logic [3:0] m1;
  logic [2:0] s10;
  logic [3:0] s1d;
  logic       fast;
  logic       day;

  time_register #(.FAST_SET_DELAY(DELAY)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_en         (en),
    .i_1hz_stb    (s1),
    .i_timeset_stb(ts),
    .i_set_hours  (sh),
    .i_set_minutes(sm),
    .o_hours_tens (h10),
    .o_hours_ones (h1),
    .o_min_tens   (m10),
    .o_min_ones   (m1),
    .o_sec_tens   (s10),
    .o_sec_ones   (s1d),
    .o_fast_set   (fast),
    .o_day_stb    (day)
  );

  always #5 clk = ~clk;

  // Model: time as seconds-of-day, mode 0=run 1=set-min 2=set-hrs.
  int mt    = 0;
  int mmode = 0;
  int mcnt  = 0;
  int mfast = 0;
  int mday  = 0;

  int vectors     = 0;
  int miscompares = 0;

  always @(posedge clk or posedge rst) begin
    int nm;
    int hh;
    int mm;
    if (rst) begin
      mt = 0; mmode = 0; mcnt = 0; mfast = 0; mday = 0;
    end else begin
      nm   = sh ? 2 : (sm ? 1 : 0);
      mday = 0;
      if (en) begin
        if (nm == 0 && s1) begin
          mt = mt + 1;
          if (mt == 86400) begin
            mt   = 0;
            mday = 1;
          end
        end
        if (nm == 1 && ts) begin
          hh = mt / 3600;
          mm = ((mt / 60) % 60 + 1) % 60;
          mt = hh * 3600 + mm * 60;
        end
        if (nm == 2 && ts) begin
          mt = ((mt / 3600 + 1) % 24) * 3600 + mt % 3600;
        end
      end
      if (nm != mmode) mcnt = (en && ts && nm != 0) ? 1 : 0;
      else if (en && ts && nm != 0 && mcnt < DELAY) mcnt = mcnt + 1;
      mfast = (mcnt == DELAY) ? 1 : 0;
      mmode = nm;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    int hh, mm, ss;
    hh = mt / 3600;
    mm = (mt / 60) % 60;
    ss = mt % 60;
    check("hours_tens", int'(h10), hh / 10);
    check("hours_ones", int'(h1),  hh % 10);
    check("min_tens",   int'(m10), mm / 10);
    check("min_ones",   int'(m1),  mm % 10);
    check("sec_tens",   int'(s10), ss / 10);
    check("sec_ones",   int'(s1d), ss % 10);
    check("fast_set",   int'(fast), mfast);
    check("day_stb",    int'(day),  mday);
  endtask

  // Hand-computed literal expectations; also pin the model's own time.
  task automatic check_time(input string tag, input int hh, input int mm, input int ss);
    check({tag, "_h10"}, int'(h10), hh / 10);
    check({tag, "_h1"},  int'(h1),  hh % 10);
    check({tag, "_m10"}, int'(m10), mm / 10);
    check({tag, "_m1"},  int'(m1),  mm % 10);
    check({tag, "_s10"}, int'(s10), ss / 10);
    check({tag, "_s1"},  int'(s1d), ss % 10);
    check({tag, "_model"}, mt, hh * 3600 + mm * 60 + ss);
  endtask

  // One clock: drive inputs with clk low, compare on the following negedge.
  task automatic cyc(input logic h, input logic m, input logic e,
                     input logic a, input logic b);
    sh = h; sm = m; en = e; s1 = a; ts = b;
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    @(negedge clk);
    compare_model();
    check_time("reset", 0, 0, 0);
    check("reset_fast", int'(fast), 0);
    check("reset_day", int'(day), 0);
    rst = 1'b0;

    // First strobe after reset is counted.
    cyc(0, 0, 1, 1, 0);
    check_time("first_after_reset", 0, 0, 1);

    // Reach 23:59:59 via set modes and run strobes.
    repeat (23) cyc(1, 0, 1, 0, 1);
    check("fast_hold_hrs", int'(fast), 1);
    check_time("hrs_23", 23, 0, 1);
    repeat (59) cyc(0, 1, 1, 0, 1);
    check_time("min_59", 23, 59, 0);
    cyc(0, 0, 1, 0, 0);
    check("fast_clear_run", int'(fast), 0);
    repeat (59) cyc(0, 0, 1, 1, 0);
    check_time("pre_roll", 23, 59, 59);
    cyc(0, 0, 1, 1, 0);
    check_time("roll", 0, 0, 0);
    check("roll_day", int'(day), 1);
    cyc(0, 0, 1, 0, 0);
    check("roll_day_drop", int'(day), 0);

    // 12:59:30, set-minutes strobe wraps minutes without carry, clears seconds.
    repeat (12) cyc(1, 0, 1, 0, 1);
    repeat (59) cyc(0, 1, 1, 0, 1);
    cyc(0, 0, 1, 0, 0);
    repeat (30) cyc(0, 0, 1, 1, 0);
    check_time("pre_setmin", 12, 59, 30);
    cyc(0, 1, 1, 1, 1);
    check_time("setmin_wrap", 12, 0, 0);
    check("setmin_day", int'(day), 0);
    repeat (3) cyc(0, 1, 1, 1, 0);
    check_time("setmin_1hz_ignored", 12, 0, 0);

    // Fast-set threshold and clear on SET_HRS -> SET_MIN.
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    repeat (7) cyc(1, 0, 1, 0, 1);
    check("fast_after_7", int'(fast), 0);
    cyc(1, 0, 1, 0, 1);
    check("fast_after_8", int'(fast), 1);
    cyc(0, 1, 1, 0, 0);
    check("fast_after_switch", int'(fast), 0);
    check_time("after_fast", 20, 0, 0);

    // 23:10:05, both buttons: hours win.
    repeat (10) cyc(0, 1, 1, 0, 1);
    cyc(0, 0, 1, 0, 0);
    repeat (5) cyc(0, 0, 1, 1, 0);
    repeat (3) cyc(1, 0, 1, 0, 1);
    check_time("pre_both", 23, 10, 5);
    cyc(1, 1, 1, 0, 1);
    check_time("both_hrs_priority", 0, 10, 5);
    check("both_day", int'(day), 0);

    // Enable low: everything holds.
    cyc(0, 0, 1, 0, 0);
    repeat (5) cyc(0, 0, 0, 1, 0);
    check_time("en_low_1hz", 0, 10, 5);
    cyc(1, 0, 0, 0, 1);
    check_time("en_low_set", 0, 10, 5);
    check("en_low_fast", int'(fast), 0);
    cyc(0, 0, 1, 0, 0);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    compare_model();
    check_time("async_reset", 0, 0, 0);
    @(negedge clk);
    compare_model();
    rst = 1'b0;
    cyc(0, 0, 1, 1, 0);
    check_time("after_async_reset", 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/time_register.md
TIME_REGISTER -- requirements
Module: time_register

Interface
- REQ-001 The block SHALL have parameter FAST_SET_DELAY, default 8: number of applied timeset strobes in one set mode before o_fast_set asserts.
- REQ-002 The block SHALL have port i_clk, input, 1 bit: single system clock; all logic rising-edge.
- REQ-003 The block SHALL have port i_reset, input, 1 bit: reset, asynchronous, active-high.
- REQ-004 The block SHALL have port i_en, input, 1 bit: global enable; when low, all strobes are ignored.
- REQ-005 The block SHALL have port i_1hz_stb, input, 1 bit: one-cycle 1 Hz timekeeping strobe.
- REQ-006 The block SHALL have port i_timeset_stb, input, 1 bit: one-cycle time-adjust strobe.
- REQ-007 The block SHALL have ports i_set_hours and i_set_minutes, inputs, 1 bit each: debounced, synchronous set buttons.
- REQ-008 The block SHALL have ports o_hours_tens, o_hours_ones, o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, outputs, widths 2/4/3/4/3/4: BCD time, 24 h format.
- REQ-009 The block SHALL have port o_fast_set, output, 1 bit: speed request back to the timeset strobe generator.
- REQ-010 The block SHALL have port o_day_stb, output, 1 bit: one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.

Function
- REQ-011 The block SHALL use FSM states RUN, SET_HRS and SET_MIN; the next state is SET_HRS if i_set_hours=1 (priority when both buttons are high), else SET_MIN if i_set_minutes=1, else RUN.
- REQ-012 In RUN, each i_1hz_stb with i_en=1 SHALL advance seconds; seconds wrap 59->00 and carry into minutes; minutes wrap 59->00 and carry into hours; hours wrap 23->00.
- REQ-013 All time outputs SHALL be registered, and a counted strobe SHALL be visible on the outputs on the clock edge after the one that samples it (latency 1).
- REQ-014 o_day_stb SHALL pulse high for exactly one cycle, coincident with the outputs showing 00:00:00 after a RUN carry from 23:59:59; it SHALL never pulse from set-mode increments.
- REQ-015 In SET_MIN and SET_HRS, i_1hz_stb SHALL be ignored.
- REQ-016 In SET_MIN, each i_timeset_stb SHALL increment minutes modulo 60 with no carry into hours, and SHALL clear seconds to 00.
- REQ-017 In SET_HRS, each i_timeset_stb SHALL increment hours modulo 24, leaving minutes and seconds unchanged.
- REQ-018 On the first cycle in a new state, a strobe SHALL be applied according to the new state.
- REQ-019 A strobe counter SHALL count applied i_timeset_stb pulses while in the current set state, saturating at FAST_SET_DELAY.
- REQ-020 o_fast_set SHALL be registered and equal 1 when the strobe counter equals FAST_SET_DELAY.
- REQ-021 The strobe counter and o_fast_set SHALL clear on any state change, including SET_HRS <-> SET_MIN.
- REQ-022 When i_en=0, time digits, the strobe counter and o_fast_set SHALL hold; the FSM SHALL still track the buttons.
- REQ-023 BCD digits SHALL never hold an illegal value: tens-of-hours <= 2, hours <= 23, tens-of-minutes and tens-of-seconds <= 5, ones digits <= 9.

Reset
- REQ-024 Asserting i_reset SHALL immediately, without a clock edge, set time to 00:00:00, o_fast_set=0, o_day_stb=0, the strobe counter to 0, and the state to RUN.
- REQ-025 Reset asserted mid-operation, including mid-set or mid-carry, SHALL discard the partial update.
- REQ-026 The first strobe after reset deassertion SHALL be counted normally.

Structure
- REQ-027 A shared package/header SHALL hold the FSM state encodings and the BCD limit constants (59, 23, digit maxima).
- REQ-028 The design SHALL contain one sub-module, bcd_mod_counter: a two-digit BCD counter with parameterised modulus, increment input, clear input and carry-out, instantiated three times.
- REQ-029 The hours instance of bcd_mod_counter SHALL handle the 23->00 rule.

Verification
- REQ-030 Preload 23:59:59 in RUN, apply one i_1hz_stb -> next cycle outputs 00:00:00 and o_day_stb=1 for exactly one cycle.
- REQ-031 At 12:59:30, hold i_set_minutes and apply one i_timeset_stb -> 12:00:00; o_day_stb stays 0; i_1hz_stb ignored while held.
- REQ-032 Hold i_set_hours, apply 7 i_timeset_stb -> o_fast_set=0; 8th strobe -> o_fast_set=1; switch to i_set_minutes -> o_fast_set=0 the next cycle.
- REQ-033 Both buttons high at 23:10:05, apply one i_timeset_stb -> 00:10:05 (hours priority).
- REQ-034 With i_en=0, apply 5 i_1hz_stb -> time unchanged; assert i_reset between clock edges -> outputs 00:00:00 immediately.
